custom_logic_rx: RTL and testbench
==================================

Name: custom_logic_rx

Overview:
- Receive-side decoder for the stream produced by the custom_logic transform. Odd words appear once on that stream; even words appear as two identical back-to-back beats.
- This block collapses each even pair back into a single beat and tags it as doubled. Odd words pass through untagged.
- It detects broken pairs, flags them, and keeps running counts.
- It sits directly downstream of the transform, before the sink.

Parameters:
- DW, 6, data width of input and output words.
- WCW, 16, width of word_count.
- ECW, 8, width of err_count.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DW  word from the transform's downstream port.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  DW  collapsed word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts out_data.
- out_doubled  output  1  with out_valid: word came from a matched even pair.
- out_err  output  1  with out_valid: word is the first half of a broken pair.
- err_pulse  output  1  one-cycle pulse on each broken-pair detection.
- word_count  output  WCW  output beats accepted by the sink, wraps.
- err_count  output  ECW  broken pairs detected, saturating.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; held register cleared; out_valid=0, out_data=0, out_doubled=0, out_err=0, err_pulse=0, word_count=0, err_count=0. Reset mid-pair discards the held word.
- Handshakes:
  - Input beat transfers when in_valid && in_ready.
  - Output beat transfers when out_valid && out_ready.
  - out_data and its tags are stable while out_valid && !out_ready.
- Output stage is a single registered slot. slot_free = !out_valid || out_ready. A load occurs in the same cycle a transfer frees the slot.
- FSM states: IDLE, PAIR.
- IDLE:
  - in_ready = slot_free.
  - Odd beat (in_data[0]=1) accepted: load slot with in_data, doubled=0, err=0; stay IDLE.
  - Even beat accepted: store in held; go to PAIR; slot not loaded.
- PAIR:
  - in_ready = slot_free && (in_data == held).
  - Matching beat accepted: load slot with held, doubled=1, err=0; go to IDLE.
  - Mismatch (in_valid && slot_free && in_data != held): load slot with held, doubled=0, err=1; err_pulse=1 for that cycle; err_count increments, saturating at all-ones; go to IDLE. The mismatching beat is NOT consumed and is re-evaluated in IDLE on the following cycle.
  - If !slot_free, nothing happens; stay in PAIR.
- Latency (input acceptance to out_valid):
  - Odd word: 1 cycle.
  - Even pair: 1 cycle after the second beat is accepted.
  - Mismatch: 1 cycle after detection.
- Throughput: with out_ready held high, one input beat per cycle. A mismatch costs one extra cycle.
- word_count increments on each output transfer and wraps modulo 2^WCW.
- in_ready is combinational from state, in_data and out_valid/out_ready. No combinational path exists from in_valid to in_ready.
- Even beats with value 0 are legal and are paired like any other even value.

Test Plan:
- DW=6, out_ready=1, single beat 5 → cycle after acceptance out_data=5, doubled=0, err=0; word_count=1.
- Beats 16,16 on consecutive cycles → in_ready high both cycles; exactly one output 16 with doubled=1, one cycle after the second beat; err_count=0.
- Beats 16 then 9 → output 16 with err=1 and err_pulse high one cycle; in_ready low on the 9 in that cycle; next output 9, doubled=0; err_count=1.
- Stream 3,4,4,7 with out_ready low for 5 cycles then high → in_ready drops once the slot is full; no loss, no duplication; outputs 3, 4(doubled), 7 in order; word_count=3.
- Beat 36 accepted, then rst for 1 cycle, then 36,36 → exactly one output 36 with doubled=1; all counters 0 before it.
- 260 consecutive broken pairs (even word, then a different odd word) → err_count saturates at 255; err_pulse still fires 260 times.

Source files
------------

// File: rtl/custom_logic_rx.sv
// Collapses the transform's doubled even-word pairs back into single beats tagged as doubled,
// flags broken pairs, and keeps a wrapping output-beat count and a saturating broken-pair count.
module custom_logic_rx #(
    parameter int DW  = 6,
    parameter int WCW = 16,
    parameter int ECW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [DW-1:0]  out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_doubled,
    output logic           out_err,
    output logic           err_pulse,
    output logic [WCW-1:0] word_count,
    output logic [ECW-1:0] err_count
);
    typedef enum logic {IDLE, PAIR} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] held;
    logic          slot_free;
    logic          match;
    logic          load;
    logic [DW-1:0] load_data;
    logic          load_dbl;
    logic          load_err;
    logic          hold_en;
    logic          mismatch;

    assign slot_free = !out_valid || out_ready;
    assign match     = (in_data == held);
    assign err_pulse = mismatch;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        load_data = in_data;
        load_dbl  = 1'b0;
        load_err  = 1'b0;
        hold_en   = 1'b0;
        mismatch  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    if (in_data[0]) begin
                        load = 1'b1;
                    end else begin
                        hold_en   = 1'b1;
                        state_nxt = PAIR;
                    end
                end
            end
            PAIR: begin
                in_ready = slot_free && match;
                // A mismatching beat is left on the input and re-examined from IDLE next cycle.
                if (in_valid && slot_free) begin
                    load      = 1'b1;
                    load_data = held;
                    load_dbl  = match;
                    load_err  = !match;
                    mismatch  = !match && !rst;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            held        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_doubled <= 1'b0;
            out_err     <= 1'b0;
            word_count  <= '0;
            err_count   <= '0;
        end else begin
            state <= state_nxt;
            if (hold_en) begin
                held <= in_data;
            end
            if (load) begin
                out_valid   <= 1'b1;
                out_data    <= load_data;
                out_doubled <= load_dbl;
                out_err     <= load_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) begin
                word_count <= word_count + 1'b1;
            end
            if (mismatch && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_custom_logic_rx.sv
// Directed bench for custom_logic_rx: a per-cycle vector table plus stream sequences
// for backpressure, reset mid-pair and error-count saturation.
module tb_custom_logic_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_doubled;
    logic        out_err;
    logic        err_pulse;
    logic [15:0] word_count;
    logic [7:0]  err_count;

    int checks = 0;
    int failures = 0;

    custom_logic_rx #(.DW(6), .WCW(16), .ECW(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_doubled(out_doubled), .out_err(out_err), .err_pulse(err_pulse),
        .word_count(word_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [5:0] d;
        logic       ordy;
        logic       e_irdy;
        logic       e_ov;
        logic [5:0] e_od;
        logic       e_dbl;
        logic       e_err;
        logic       e_ep;
        int         e_wc;
        int         e_ec;
    } vec_t;

    typedef struct packed {
        logic [5:0] d;
        logic       dbl;
        logic       err;
    } beat_t;

    logic [5:0] src_q[$];
    beat_t      got_q[$];
    beat_t      exp_q[$];
    int         pulse_cnt;
    int         stall_bad;
    int         irdy_low_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Feeds src_q with valid/ready, holds out_ready low for the first 'stall' cycles,
    // and collects every accepted output beat into got_q.
    task automatic run_stream(input int stall);
        int   idx = 0;
        int   extra = 0;
        bit   done = 0;
        bit   prev_stall = 0;
        beat_t prev = '0;
        int   budget = 3 * src_q.size() + stall + 20;
        got_q.delete();
        pulse_cnt = 0; stall_bad = 0; irdy_low_seen = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            in_valid  = (idx < src_q.size());
            in_data   = (idx < src_q.size()) ? src_q[idx] : 6'd0;
            out_ready = (c >= stall);
            @(negedge clk);
            if (prev_stall && (!out_valid || out_data != prev.d ||
                               out_doubled != prev.dbl || out_err != prev.err))
                stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev = '{out_data, out_doubled, out_err};
            if (out_valid && !out_ready) begin
                if (in_ready) stall_bad++;
                else irdy_low_seen++;
            end
            if (err_pulse) pulse_cnt++;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got_q.push_back('{out_data, out_doubled, out_err});
            if (idx == src_q.size()) begin
                extra++;
                if (extra >= 4) done = 1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (!done) begin
            checks++; failures++;
            $display("FAIL stream_timeout: consumed %0d of %0d beats", idx, src_q.size());
        end
    endtask

    task automatic cmp_stream(input string name);
        int bad = 0;
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        chk({name, "_content_mismatches"}, bad, 0);
    endtask

    vec_t tbl[11];

    initial begin
        //            vld d   ordy irdy ov od  dbl err ep wc ec
        tbl[0]  = '{1, 5,  1, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0,  1, 1, 1, 5,  0, 0, 0, 0, 0};
        tbl[2]  = '{1, 16, 1, 1, 0, 0,  0, 0, 0, 1, 0};
        tbl[3]  = '{1, 16, 1, 1, 0, 0,  0, 0, 0, 1, 0};
        tbl[4]  = '{1, 16, 1, 1, 1, 16, 1, 0, 0, 1, 0};
        tbl[5]  = '{1, 9,  1, 0, 0, 0,  0, 0, 1, 2, 0};
        tbl[6]  = '{1, 9,  1, 1, 1, 16, 0, 1, 0, 2, 1};
        tbl[7]  = '{1, 0,  1, 1, 1, 9,  0, 0, 0, 3, 1};
        tbl[8]  = '{1, 0,  1, 1, 0, 0,  0, 0, 0, 4, 1};
        tbl[9]  = '{0, 0,  1, 1, 1, 0,  1, 0, 0, 4, 1};
        tbl[10] = '{0, 0,  1, 1, 0, 0,  0, 0, 0, 5, 1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_tags", {out_doubled, out_err, err_pulse}, 0);
        chk("reset_word_count", word_count, 0);
        chk("reset_err_count", err_count, 0);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            in_valid = tbl[i].vld; in_data = tbl[i].d; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_irdy);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
                chk($sformatf("vec%0d_doubled", i), out_doubled, tbl[i].e_dbl);
                chk($sformatf("vec%0d_err", i), out_err, tbl[i].e_err);
            end
            chk($sformatf("vec%0d_err_pulse", i), err_pulse, tbl[i].e_ep);
            chk($sformatf("vec%0d_word_count", i), word_count, tbl[i].e_wc);
            chk($sformatf("vec%0d_err_count", i), err_count, tbl[i].e_ec);
        end

        // Backpressure: 3,4,4,7 with sink stalled for five cycles.
        do_reset();
        src_q = '{6'd3, 6'd4, 6'd4, 6'd7};
        exp_q = '{'{6'd3, 1'b0, 1'b0}, '{6'd4, 1'b1, 1'b0}, '{6'd7, 1'b0, 1'b0}};
        run_stream(5);
        cmp_stream("bp");
        chk("bp_stall_violations", stall_bad, 0);
        chk("bp_in_ready_dropped", irdy_low_seen > 0, 1);
        chk("bp_word_count", word_count, 3);
        chk("bp_err_count", err_count, 0);

        // Reset while an even word is held: the held word is dropped.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 6'd36; out_ready = 1'b1;
        @(negedge clk);
        chk("rstpair_first_accept", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstpair_word_count", word_count, 0);
        chk("rstpair_err_count", err_count, 0);
        chk("rstpair_out_valid", out_valid, 0);
        src_q = '{6'd36, 6'd36};
        exp_q = '{'{6'd36, 1'b1, 1'b0}};
        run_stream(0);
        cmp_stream("rstpair");
        chk("rstpair_final_word_count", word_count, 1);

        // 260 broken pairs: err_count saturates, err_pulse keeps firing.
        do_reset();
        src_q.delete(); exp_q.delete();
        for (int k = 0; k < 260; k++) begin
            logic [5:0] ev;
            ev = 6'((k * 2) % 64);
            src_q.push_back(ev);
            src_q.push_back(ev | 6'd1);
            exp_q.push_back('{ev, 1'b0, 1'b1});
            exp_q.push_back('{ev | 6'd1, 1'b0, 1'b0});
        end
        run_stream(0);
        cmp_stream("sat");
        chk("sat_err_pulses", pulse_cnt, 260);
        chk("sat_err_count", err_count, 255);
        chk("sat_word_count", word_count, 520);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
